bus_arbiter_rr: RTL

- Round-robin arbiter and transaction sequencer that shares one target bus of the `ifa` family (req/gnt/start/rdy, 2-bit mode, 8-bit addr/data) between NREQ CPU-core requesters.
- Grants one requester at a time, launches a single-beat read or write on the shared bus, and waits for the target's rdy.
- Returns read data and a completion pulse, with a timeout/error path.
- Sits between the cpucore instances and the shared bus target.

---
 rtl/bus_arb_pkg.sv | 35 +++
 rtl/rr_picker.sv | 37 +++
 rtl/bus_arbiter_rr.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and widths for the round-robin bus arbiter.
package bus_arb_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned MODE_W = 2;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      MODE_NOP   = 2'b00,
      MODE_READ  = 2'b01,
      MODE_WRITE = 2'b10,
      MODE_RSVD  = 2'b11
   } bus_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } arb_state_e;

   // Command latched from the winning requester.
   typedef struct packed {
      bus_mode_e          mode;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  wdata;
   } bus_cmd_t;

   // Only reads and writes actually drive the shared bus.
   function automatic logic mode_is_xfer(input bus_mode_e m);
      return (m == MODE_READ) || (m == MODE_WRITE);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request at index >= ptr, wrapping.
module rr_picker #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    valid,
   output logic [$clog2(NREQ)-1:0] winner
);

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned SUM_W = IDX_W + 1;

   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [IDX_W-1:0]  w_off;
   logic [SUM_W-1:0]  w_sum;

   // Rotate so that bit 0 corresponds to the pointer position.
   assign w_dbl = {req, req};
   assign w_rot = NREQ'(w_dbl >> ptr);

   // Lowest set bit of the rotated vector.
   always_comb begin
      w_off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = IDX_W'(i);
      end
   end

   // Un-rotate with an explicit wrap (NREQ need not be a power of two).
   assign w_sum  = SUM_W'(ptr) + SUM_W'(w_off);
   assign winner = (w_sum > SUM_W'(NREQ - 1)) ? IDX_W'(w_sum - SUM_W'(NREQ))
                                              : IDX_W'(w_sum);
   assign valid  = |req;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and single-beat transaction sequencer for a shared ifa bus.
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [MODE_W*NREQ-1:0]   req_mode,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [DATA_W*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic [DATA_W-1:0]        rdata,
   output logic                     bus_start,
   output logic [MODE_W-1:0]        bus_mode,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [DATA_W-1:0]        bus_wdata,
   input  logic                     bus_rdy,
   input  logic [DATA_W-1:0]        bus_rdata
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   arb_state_e          r_state,  w_state_nxt;
   logic [NREQ-1:0]     r_gnt,    w_gnt_nxt;
   logic [NREQ-1:0]     r_done,   w_done_nxt;
   logic                r_err,    w_err_nxt;
   logic [DATA_W-1:0]   r_rdata,  w_rdata_nxt;
   logic                r_start,  w_start_nxt;
   bus_cmd_t            r_cmd,    w_cmd_nxt;
   logic [IDX_W-1:0]    r_winner, w_winner_nxt;
   logic [IDX_W-1:0]    r_ptr,    w_ptr_nxt;
   logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;

   logic                w_pick_vld;
   logic [IDX_W-1:0]    w_pick_idx;
   bus_cmd_t            w_sel_cmd;
   logic [NREQ-1:0]     w_win_1h;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req    (req),
      .ptr    (r_ptr),
      .valid  (w_pick_vld),
      .winner (w_pick_idx)
   );

   assign w_win_1h = NREQ'(1) << r_winner;

   // Mux out the picked requester's command; write data only travels with writes.
   always_comb begin
      w_sel_cmd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick_idx == IDX_W'(i)) begin
            w_sel_cmd.mode  = bus_mode_e'(req_mode[i*MODE_W +: MODE_W]);
            w_sel_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_cmd.wdata = (bus_mode_e'(req_mode[i*MODE_W +: MODE_W]) == MODE_WRITE)
                              ? req_wdata[i*DATA_W +: DATA_W] : '0;
         end
      end
   end

   // Next-state and next-output logic; strobes default low, everything else holds.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_done_nxt   = '0;
      w_err_nxt    = r_err;
      w_rdata_nxt  = r_rdata;
      w_start_nxt  = 1'b0;
      w_cmd_nxt    = r_cmd;
      w_winner_nxt = r_winner;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = r_cnt;

      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_winner_nxt = w_pick_idx;
               w_cmd_nxt    = w_sel_cmd;
               w_gnt_nxt    = NREQ'(1) << w_pick_idx;
               w_start_nxt  = mode_is_xfer(w_sel_cmd.mode);
               w_state_nxt  = LAUNCH;
            end
         end
         LAUNCH: begin
            w_cnt_nxt = '0;
            if (mode_is_xfer(r_cmd.mode)) begin
               w_state_nxt = WAIT;
            end else begin
               w_done_nxt  = w_win_1h;
               w_err_nxt   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         WAIT: begin
            if (bus_rdy) begin
               if (r_cmd.mode == MODE_READ) w_rdata_nxt = bus_rdata;
               w_err_nxt   = 1'b0;
               w_done_nxt  = w_win_1h;
               w_state_nxt = DONE;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_done_nxt  = w_win_1h;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         DONE: begin
            w_ptr_nxt   = (r_winner == IDX_W'(NREQ - 1)) ? '0 : r_winner + IDX_W'(1);
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and output registers; reset also aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_start  <= 1'b0;
         r_cmd    <= '0;
         r_winner <= '0;
         r_ptr    <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_rdata  <= w_rdata_nxt;
         r_start  <= w_start_nxt;
         r_cmd    <= w_cmd_nxt;
         r_winner <= w_winner_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign err       = r_err;
   assign rdata     = r_rdata;
   assign bus_start = r_start;
   assign bus_mode  = r_cmd.mode;
   assign bus_addr  = r_cmd.addr;
   assign bus_wdata = r_cmd.wdata;

endmodule
